// File: rtl/aes_spi_ctrl_pkg.sv
// Shared definitions for the SPI-fed AES controller: FSM states, error codes
// and the AES block width.
package aes_spi_ctrl_pkg;

    localparam int BLOCK_W = 128;

    typedef enum logic [2:0] {
        IDLE,
        KEY_RX,
        DATA_RX,
        RUN,
        LOAD
    } state_t;

    localparam logic [1:0] ERR_NONE    = 2'd0;
    localparam logic [1:0] ERR_SHORT   = 2'd1;
    localparam logic [1:0] ERR_TIMEOUT = 2'd2;

endpackage

// File: rtl/aes_spi_ctrl_watchdog.sv
// Saturating cycle counter that flags the TIMEOUT-th enabled cycle without
// a completion, so the controller can leave RUN on that same clock edge.
module aes_watchdog #(
    parameter int TIMEOUT = 64
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic expired
);

    localparam int CW = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT);
    localparam logic [CW-1:0] LAST  = CW'(TIMEOUT - 1);

    logic [CW-1:0] count;

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            count <= '0;
        end else if (en && (count != LIMIT)) begin
            count <= count + CW'(1);
        end
    end

    // The counter reaches TIMEOUT on the edge that ends this cycle.
    assign expired = en && (count >= LAST);

endmodule

// File: rtl/aes_spi_ctrl.sv
// Controller that receives a key frame and a data frame over SPI, runs the
// AES core once, guards it with a watchdog and hands the result back for TX.
module aes_spi_ctrl
    import aes_spi_ctrl_pkg::*;
#(
    parameter int Nk      = 4,
    parameter int Nr      = 10,
    parameter int TIMEOUT = 64
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 spi_cs,
    input  logic                 spi_done,
    input  logic [Nk*32-1:0]     spi_data,
    input  logic                 mode,
    output logic                 aes_start,
    output logic [Nk*32-1:0]     aes_key,
    output logic [BLOCK_W-1:0]   aes_in,
    output logic                 aes_dec,
    input  logic                 aes_done,
    input  logic [BLOCK_W-1:0]   aes_out,
    output logic                 tx_load,
    output logic [BLOCK_W-1:0]   tx_data,
    output logic                 busy,
    output logic [1:0]           err
);

    if (!((Nk == 4 || Nk == 6 || Nk == 8) && Nr == Nk + 6)) begin : g_bad_cfg
        $error("aes_spi_ctrl: unsupported Nk/Nr combination");
    end

    state_t state, state_next;
    logic   cs_prev;
    logic   cs_fall, cs_rise;
    logic   wd_clr, wd_en, wd_expired;

    logic                 start_next, dec_next, load_next;
    logic [Nk*32-1:0]     key_next;
    logic [BLOCK_W-1:0]   in_next, tx_next;
    logic [1:0]           err_next;

    assign cs_fall = cs_prev && !spi_cs;
    assign cs_rise = !cs_prev && spi_cs;
    assign wd_en   = (state == RUN);

    aes_watchdog #(.TIMEOUT(TIMEOUT)) u_watchdog (
        .clk     (clk),
        .rst     (rst),
        .clr     (wd_clr),
        .en      (wd_en),
        .expired (wd_expired)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        start_next = 1'b0;
        load_next  = 1'b0;
        wd_clr     = 1'b0;
        key_next   = aes_key;
        in_next    = aes_in;
        dec_next   = aes_dec;
        tx_next    = tx_data;
        err_next   = err;
        case (state)
            IDLE: begin
                if (cs_fall) begin
                    state_next = KEY_RX;
                    err_next   = ERR_NONE;
                end
            end
            KEY_RX: begin
                if (cs_rise) begin
                    if (spi_done) begin
                        key_next   = spi_data;
                        dec_next   = mode;
                        state_next = DATA_RX;
                    end else begin
                        err_next   = ERR_SHORT;
                        state_next = IDLE;
                    end
                end
            end
            DATA_RX: begin
                if (cs_rise) begin
                    if (spi_done) begin
                        in_next    = spi_data[BLOCK_W-1:0];
                        start_next = 1'b1;
                        wd_clr     = 1'b1;
                        state_next = RUN;
                    end else begin
                        err_next   = ERR_SHORT;
                        state_next = IDLE;
                    end
                end
            end
            RUN: begin
                // A completion arriving with the expiry still counts as success.
                if (aes_done) begin
                    tx_next    = aes_out;
                    load_next  = 1'b1;
                    state_next = LOAD;
                end else if (wd_expired) begin
                    err_next   = ERR_TIMEOUT;
                    state_next = IDLE;
                end
            end
            LOAD: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cs_prev   <= 1'b1;
            aes_start <= 1'b0;
            aes_key   <= '0;
            aes_in    <= '0;
            aes_dec   <= 1'b0;
            tx_load   <= 1'b0;
            tx_data   <= '0;
            busy      <= 1'b0;
            err       <= ERR_NONE;
        end else begin
            cs_prev   <= spi_cs;
            aes_start <= start_next;
            aes_key   <= key_next;
            aes_in    <= in_next;
            aes_dec   <= dec_next;
            tx_load   <= load_next;
            tx_data   <= tx_next;
            busy      <= (state_next != IDLE);
            err       <= err_next;
        end
    end

endmodule

// File: tb/tb_aes_spi_ctrl.sv
// Self-checking bench for aes_spi_ctrl: table-driven transactions with a
// result scoreboard, plus directed error, timeout and reset sequences.
`timescale 1ns/1ps
module tb_aes_spi_ctrl;

    logic         clk = 1'b0;
    logic         rst;
    logic         spi_cs;
    logic         spi_done;
    logic [127:0] spi_data;
    logic         mode;
    logic         aes_start;
    logic [127:0] aes_key;
    logic [127:0] aes_in;
    logic         aes_dec;
    logic         aes_done;
    logic [127:0] aes_out;
    logic         tx_load;
    logic [127:0] tx_data;
    logic         busy;
    logic [1:0]   err;

    aes_spi_ctrl #(.Nk(4), .Nr(10), .TIMEOUT(64)) dut (
        .clk       (clk),
        .rst       (rst),
        .spi_cs    (spi_cs),
        .spi_done  (spi_done),
        .spi_data  (spi_data),
        .mode      (mode),
        .aes_start (aes_start),
        .aes_key   (aes_key),
        .aes_in    (aes_in),
        .aes_dec   (aes_dec),
        .aes_done  (aes_done),
        .aes_out   (aes_out),
        .tx_load   (tx_load),
        .tx_data   (tx_data),
        .busy      (busy),
        .err       (err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [127:0] key;
        logic [127:0] data;
        logic         md;
        logic [127:0] result;
        int           delay;
        bit           noise;
        logic [127:0] exp_tx;
        logic         exp_dec;
    } vec_t;

    vec_t         vecs[4];
    logic [127:0] sb_q[$];
    int           checks = 0;
    int           passed = 0;
    int           start_cnt = 0;
    int           load_cnt = 0;

    always @(posedge clk) begin
        if (aes_start === 1'b1) start_cnt <= start_cnt + 1;
        if (tx_load === 1'b1)   load_cnt  <= load_cnt + 1;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) $display("FAIL %s: got %h, want %h", nm, act, exp);
        else passed++;
    endtask

    // One SPI frame: cs low, payload, optional done flag, cs high.
    task automatic send_frame(input logic [127:0] d, input logic md, input bit ok, input bit chk_clr);
        spi_cs = 1'b0;
        tick();
        if (chk_clr) begin
            chk("err_clear_on_cs_fall", err, 0);
            chk("busy_in_key_rx", busy, 1);
        end
        spi_data = d;
        mode = md;
        tick();
        spi_done = ok;
        tick();
        spi_cs = 1'b1;
        tick();
        spi_done = 1'b0;
    endtask

    task automatic expect_load(input string nm);
        bit seen;
        int extra;
        seen = 0;
        extra = 0;
        for (int i = 0; i < 8 && !seen; i++) begin
            if (tx_load === 1'b1) seen = 1;
            else begin
                tick();
                extra++;
            end
        end
        chk({nm, "_load_seen"}, seen, 1);
        chk({nm, "_load_latency_extra"}, extra, 0);
        if (seen) begin
            if (sb_q.size() == 0) chk({nm, "_sb_empty"}, 1, 0);
            else chk({nm, "_tx_data"}, tx_data, sb_q.pop_front());
        end
    endtask

    task automatic run_txn(input vec_t v, input string nm);
        int s0, l0;
        s0 = start_cnt;
        l0 = load_cnt;
        send_frame(v.key, v.md, 1, 1);
        chk({nm, "_key"}, aes_key, v.key);
        chk({nm, "_dec"}, aes_dec, v.exp_dec);
        send_frame(v.data, ~v.md, 1, 0);
        chk({nm, "_start"}, aes_start, 1);
        chk({nm, "_in"}, aes_in, v.data);
        for (int i = 0; i < v.delay; i++) begin
            if (v.noise) begin
                if (i == 1) begin spi_cs = 1'b0; spi_data = ~v.data; end
                if (i == 3) begin spi_done = 1'b1; spi_cs = 1'b1; end
                if (i == 4) spi_done = 1'b0;
            end
            tick();
        end
        chk({nm, "_in_hold"}, aes_in, v.data);
        aes_done = 1'b1;
        aes_out = v.result;
        sb_q.push_back(v.exp_tx);
        tick();
        aes_done = 1'b0;
        aes_out = {$urandom, $urandom, $urandom, $urandom};
        expect_load(nm);
        tick();
        chk({nm, "_load_cleared"}, tx_load, 0);
        chk({nm, "_idle"}, busy, 0);
        chk({nm, "_start_pulses"}, start_cnt - s0, 1);
        chk({nm, "_load_pulses"}, load_cnt - l0, 1);
        chk({nm, "_key_hold"}, aes_key, v.key);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: got no finish, want finish");
        $fatal(1);
    end

    initial begin
        logic [127:0] k_prev, in_prev, tx_prev;
        int s0, l0;
        rst = 1'b1; spi_cs = 1'b1; spi_done = 1'b0; spi_data = '0;
        mode = 1'b0; aes_done = 1'b0; aes_out = '0;

        vecs[0] = '{128'h2b7e1516_28aed2a6_abf71588_09cf4f3c, 128'h3243f6a8_885a308d_313198a2_e0370734,
                    1'b0, 128'h3925841d_02dc09fb_dc118597_196a0b32, 5, 1'b0,
                    128'h3925841d_02dc09fb_dc118597_196a0b32, 1'b0};
        vecs[1] = '{128'h00010203_04050607_08090a0b_0c0d0e0f, 128'h69c4e0d8_6a7b0430_d8cdb780_70b4c55a,
                    1'b1, 128'h00112233_44556677_8899aabb_ccddeeff, 0, 1'b0,
                    128'h00112233_44556677_8899aabb_ccddeeff, 1'b1};
        vecs[2] = '{128'h00010203_04050607_08090a0b_0c0d0e0f, 128'h00112233_44556677_8899aabb_ccddeeff,
                    1'b0, 128'h69c4e0d8_6a7b0430_d8cdb780_70b4c55a, 20, 1'b1,
                    128'h69c4e0d8_6a7b0430_d8cdb780_70b4c55a, 1'b0};
        vecs[3] = '{128'h2b7e1516_28aed2a6_abf71588_09cf4f3c, 128'h3925841d_02dc09fb_dc118597_196a0b32,
                    1'b1, 128'h3243f6a8_885a308d_313198a2_e0370734, 1, 1'b0,
                    128'h3243f6a8_885a308d_313198a2_e0370734, 1'b1};

        repeat (3) tick();
        chk("rst_start", aes_start, 0);
        chk("rst_load", tx_load, 0);
        chk("rst_busy", busy, 0);
        chk("rst_err", err, 0);
        chk("rst_key", aes_key, 0);
        chk("rst_in", aes_in, 0);
        chk("rst_dec", aes_dec, 0);
        chk("rst_tx", tx_data, 0);
        rst = 1'b0;
        tick();

        // Stray completion while idle must be ignored.
        aes_done = 1'b1; aes_out = 128'hdead_beef;
        tick();
        aes_done = 1'b0;
        repeat (2) tick();
        chk("stray_idle_load", load_cnt, 0);
        chk("stray_idle_tx", tx_data, 0);

        for (int i = 0; i < 4; i++) run_txn(vecs[i], $sformatf("vec%0d", i));

        // Short data frame.
        s0 = start_cnt; in_prev = aes_in;
        send_frame(128'h1111_2222_3333_4444_5555_6666_7777_8888, 1'b0, 1, 1);
        k_prev = aes_key;
        chk("short_data_key_latched", aes_key, 128'h1111_2222_3333_4444_5555_6666_7777_8888);
        send_frame(128'hffff_eeee, 1'b0, 0, 0);
        chk("short_data_err", err, 1);
        chk("short_data_idle", busy, 0);
        chk("short_data_key_kept", aes_key, k_prev);
        chk("short_data_in_kept", aes_in, in_prev);
        repeat (2) tick();
        chk("short_data_no_start", start_cnt - s0, 0);

        // Short key frame; its cs fall also clears the previous err=1.
        send_frame(128'h9999, 1'b1, 0, 1);
        chk("short_key_err", err, 1);
        chk("short_key_key_kept", aes_key, k_prev);
        chk("short_key_dec_kept", aes_dec, 0);

        // Core never answers.
        l0 = load_cnt; tx_prev = tx_data;
        send_frame(vecs[0].key, 1'b0, 1, 1);
        send_frame(vecs[0].data, 1'b0, 1, 0);
        chk("to_start", aes_start, 1);
        repeat (63) tick();
        chk("to_err_before", err, 0);
        chk("to_busy_before", busy, 1);
        tick();
        chk("to_err", err, 2);
        chk("to_idle", busy, 0);
        repeat (3) tick();
        chk("to_no_load", load_cnt - l0, 0);
        chk("to_tx_kept", tx_data, tx_prev);

        // Back-to-back decrypts; the first cs fall clears err=2.
        run_txn(vecs[1], "b2b0");
        run_txn(vecs[3], "b2b1");

        // Completion in the cycle the watchdog expires.
        send_frame(vecs[2].key, 1'b0, 1, 1);
        send_frame(vecs[2].data, 1'b0, 1, 0);
        repeat (63) tick();
        aes_done = 1'b1; aes_out = 128'h0f0e0d0c_0b0a0908_07060504_03020100;
        sb_q.push_back(128'h0f0e0d0c_0b0a0908_07060504_03020100);
        tick();
        aes_done = 1'b0;
        chk("race_err", err, 0);
        expect_load("race");
        tick();
        chk("race_err_after", err, 0);
        chk("race_idle", busy, 0);

        // Reset mid-RUN followed by a stray completion.
        l0 = load_cnt;
        send_frame(vecs[0].key, 1'b1, 1, 1);
        send_frame(vecs[0].data, 1'b0, 1, 0);
        repeat (5) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        aes_done = 1'b1; aes_out = 128'h5a5a;
        tick();
        aes_done = 1'b0;
        repeat (2) tick();
        chk("rrun_key", aes_key, 0);
        chk("rrun_in", aes_in, 0);
        chk("rrun_dec", aes_dec, 0);
        chk("rrun_tx", tx_data, 0);
        chk("rrun_busy", busy, 0);
        chk("rrun_err", err, 0);
        chk("rrun_start", aes_start, 0);
        chk("rrun_no_load", load_cnt - l0, 0);
        run_txn(vecs[0], "after_rst");

        chk("sb_drained", sb_q.size(), 0);
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule

// File: doc/aes_spi_ctrl.md
AES_SPI_CTRL -- requirements
Module: aes_spi_ctrl

Interface
REQ-001 SHALL have parameter Nk, default 4, key length in 32-bit words (4, 6 or 8).
REQ-002 SHALL have parameter Nr, default 10, round count passed through to the AES core.
REQ-003 SHALL have parameter TIMEOUT, default 64, maximum number of clk cycles to wait for aes_done.
REQ-004 SHALL have port clk, input, 1 bit, single clock; all logic updates on its rising edge.
REQ-005 SHALL have port rst, input, 1 bit, synchronous active-high reset.
REQ-006 SHALL have port spi_cs, input, 1 bit, SPI chip select, active low; a frame is one low period.
REQ-007 SHALL have port spi_done, input, 1 bit, SPI receiver frame-complete flag; it is level and sticky within a frame.
REQ-008 SHALL have port spi_data, input, Nk*32 bits, SPI receive shift register contents.
REQ-009 SHALL have port mode, input, 1 bit: 0 = encrypt, 1 = decrypt; sampled together with the key.
REQ-010 SHALL have port aes_start, output, 1 bit, one-cycle start pulse to the AES core.
REQ-011 SHALL have port aes_key, output, Nk*32 bits, latched key.
REQ-012 SHALL have port aes_in, output, 128 bits, latched data block.
REQ-013 SHALL have port aes_dec, output, 1 bit, latched mode.
REQ-014 SHALL have port aes_done, input, 1 bit, one-cycle core completion pulse.
REQ-015 SHALL have port aes_out, input, 128 bits, core result; valid in the aes_done cycle.
REQ-016 SHALL have port tx_load, output, 1 bit, one-cycle pulse that loads tx_data into the SPI transmit register.
REQ-017 SHALL have port tx_data, output, 128 bits, latched result.
REQ-018 SHALL have port busy, output, 1 bit, high in any state except IDLE.
REQ-019 SHALL have port err, output, 2 bits, sticky error code: 0 none, 1 short frame, 2 timeout.

Function
REQ-020 SHALL implement FSM states IDLE, KEY_RX, DATA_RX, RUN, LOAD, plus a defined output state per REQ-030.
- Frame end = spi_cs rising edge, using a registered previous cs value.
- Frame valid = spi_done sampled high in the cycle of the cs rising edge.
REQ-021 IDLE: on spi_cs falling edge SHALL go to KEY_RX; err is cleared at that moment.
REQ-022 KEY_RX: on a valid frame end SHALL latch aes_key = spi_data and aes_dec = mode, then go to DATA_RX.
REQ-023 DATA_RX: on a valid frame end SHALL latch aes_in = spi_data[127:0], then go to RUN.
REQ-024 Entry to RUN SHALL assert aes_start for exactly one cycle, in the first RUN cycle, and clear the watchdog counter.
REQ-025 RUN: on aes_done SHALL latch tx_data = aes_out and go to LOAD, in the same cycle.
REQ-026 LOAD: SHALL assert tx_load for one cycle, then go to IDLE; latency from aes_done to tx_load is exactly 1 cycle.
REQ-027 A frame end with spi_done low in KEY_RX or DATA_RX SHALL set err=1 and return to IDLE; no latched register changes.
REQ-028 Watchdog: the counter increments each RUN cycle; when it reaches TIMEOUT without aes_done, the block SHALL set err=2 and go to IDLE with no tx_load.
- If aes_done and the TIMEOUT condition occur in the same cycle, aes_done wins.
REQ-029 SHALL ignore aes_done outside RUN, and spi_cs edges during RUN and LOAD.
REQ-030 Outputs SHALL be registered; aes_key, aes_in, aes_dec and tx_data hold their value until the next latch.
REQ-031 The watchdog counter width SHALL be $clog2(TIMEOUT+1) and SHALL saturate, never wrapping.

Reset
REQ-032 With rst high at a clk edge: state=IDLE, all outputs 0, counter 0, and the previous cs register = 1.
REQ-033 Reset SHALL take priority over every other event, including mid-RUN or mid-frame; a pending aes_done is lost.

Structure
REQ-034 A shared package SHALL hold the FSM state enum, the err code constants and the AES block width (128).
REQ-035 The watchdog SHALL be a sub-module, aes_watchdog, with inputs clr and en and output expired.

Verification
REQ-036 Key frame 0x2b7e1516_28aed2a6_abf71588_09cf4f3c with mode=0, then data frame 0x3243f6a8_885a308d_313198a2_e0370734, core returns 0x3925841d_02dc09fb_dc118597_196a0b32:
- aes_start pulses once; tx_load follows aes_done by 1 cycle; tx_data equals the core result.
REQ-037 cs rises with spi_done=0 during DATA_RX -> err=1, state IDLE, aes_start never pulses, aes_key retained.
REQ-038 Core never returns aes_done, TIMEOUT=64 -> err=2 exactly 64 cycles after aes_start; tx_load stays 0.
REQ-039 aes_done in the same cycle the watchdog expires -> tx_load is issued and err stays 0.
REQ-040 rst asserted in RUN, then a stray aes_done -> all outputs 0 and no tx_load; the next full sequence completes normally.
REQ-041 Back-to-back transactions with mode=1 -> aes_dec=1 is latched; a cs falling edge clears err from a previous failed transaction.
